exception_unit: RTL and testbench
=================================

Name: exception_unit

Overview:
- Commit-point exception collector for the dual-issue pipeline; sits directly upstream of the CP0 register file.
- Each cycle it takes the two committing slots, synchronised external interrupts and the live CP0 Status/Cause fields.
- It picks the highest-priority event and drives the CP0 exception-input bundle (exception_en, ExeCode, EPC, BadVAddr, BD), the eret pulse, the pipeline flush and the fetch redirect.
- A small FSM holds the flush for a fixed window and blocks re-entry while the pipeline drains.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, fetch redirect target for any exception or interrupt.
- FLUSH_CYCLES, 3, total cycles flush stays high per event (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- slot_valid  in  2  committing-slot valid; [0] is older
- slot_pc  in  2x32  PC per slot
- slot_in_ds  in  2  slot instruction is in a branch delay slot
- slot_adel_if  in  2  fetch address error; BadVAddr is the slot PC
- slot_ri, slot_ov, slot_sys, slot_bp  in  2 each  reserved-instr / overflow / syscall / break
- slot_adel_d, slot_ades_d  in  2 each  data load / store address error
- slot_vaddr  in  2x32  data virtual address
- slot_eret  in  2  eret committing
- ext_int  in  6  asynchronous hardware interrupt lines
- status_ie, status_exl  in  1 each  live CP0 Status bits
- status_im  in  8  live Status.IM
- cause_ip_sw  in  2  live Cause.IP[1:0]
- cause_ti  in  1  live Cause.TI
- epc_in  in  32  live CP0 EPC (eret target)
- exception_en  out  1  one-cycle pulse into CP0
- exc_code  out  5  ExcCode
- exc_epc  out  32  EPC value
- exc_badvaddr  out  32  BadVAddr value
- exc_bd  out  1  branch-delay flag
- eret_out  out  1  one-cycle pulse to CP0 (clears EXL)
- ip_hw  out  6  synchronised interrupt lines, for Cause.IP[7:2]
- flush  out  1  pipeline flush
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  32  redirect target

Behaviour:
- Reset (async): every output and state register goes to 0; FSM goes to IDLE; sync flops clear.
- ext_int passes through a 2-flop synchroniser; ip_hw is the second stage.
- int_req = status_ie & ~status_exl & |(status_im & {ip_hw[5] | cause_ti, ip_hw[4:0], cause_ip_sw}).
- ExcCode values: Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12.
- Per-slot priority: adel_if > ri > ov > sys > bp > adel_d > ades_d.
- Global priority:
  - int_req with slot_valid[0] wins, attached to slot 0.
  - Otherwise a slot 0 exception wins.
  - Otherwise a slot 1 exception wins, only if slot_valid[1] and slot 0 carries no eret.
  - int_req with slot_valid[0]=0 is not taken; it stays pending through int_req.
- Invalid slots are ignored entirely.
- EPC = in_ds ? pc-4 : pc (32-bit wrap); BD = in_ds.
- BadVAddr = pc for adel_if, vaddr for adel_d/ades_d, otherwise 0.
- eret is taken only in slot 0 when no exception or interrupt is chosen; an eret in slot 1 alone is ignored.
- FSM IDLE:
  - On a selected event at posedge N, register the outputs. Cycle N+1 shows one of two sets:
    - Exception: exception_en=1, redirect_valid=1, redirect_pc=EXC_VECTOR, flush=1, fields valid.
    - eret: eret_out=1, redirect_valid=1, redirect_pc=epc_in sampled at N, flush=1.
  - Next state is HOLD if FLUSH_CYCLES>1, else IDLE.
- FSM HOLD:
  - flush=1; all pulses 0; exc fields hold their last values.
  - All slot inputs and int_req are ignored.
  - A down-counter returns the FSM to IDLE after FLUSH_CYCLES-1 cycles.
- In IDLE with no event, all pulse outputs are 0 and fields hold.
- status_exl=1 does not suppress synchronous exceptions; exception_en still pulses, and CP0 decides whether to latch.
- Reset mid-HOLD aborts immediately; nothing is replayed.

Test Plan:
1. slot0 valid, pc=32'h8000_1000, ov=1 -> next cycle exception_en=1, exc_code=12, exc_epc=32'h8000_1000, bd=0, redirect_pc=32'hBFC0_0380; flush high 3 cycles.
2. slot0 in_ds, pc=32'h8000_2004, ades_d, vaddr=32'h0000_0003; slot1 sys -> exc_code=5, epc=32'h8000_2000, bd=1, badvaddr=32'h0000_0003; slot1 ignored.
3. ie=1, exl=0, im=8'h04, ext_int[0] rises -> ip_hw[0] after 2 clks; with slot0 valid pc=32'h8000_3000, exc_code=0, epc=32'h8000_3000. Repeat with exl=1 -> no exception.
4. slot0 eret, epc_in=32'h8000_4000 -> eret_out=1, redirect_pc=32'h8000_4000, exception_en=0. slot1-only eret -> no action.
5. Exception followed by a new ri on the next two cycles -> ignored during HOLD; an ri on cycle 4 is taken.
6. Assert reset during HOLD -> flush, pulses and state are 0 in the same cycle; an event after reset release is handled normally.

Source files
------------

// File: rtl/exception_unit.sv
// Commit-point exception collector: picks the highest-priority interrupt, exception
// or eret from the two committing slots and drives CP0, flush and fetch redirect.
module exception_unit #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int          FLUSH_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       slot_valid,
  input  logic [1:0][31:0] slot_pc,
  input  logic [1:0]       slot_in_ds,
  input  logic [1:0]       slot_adel_if,
  input  logic [1:0]       slot_ri,
  input  logic [1:0]       slot_ov,
  input  logic [1:0]       slot_sys,
  input  logic [1:0]       slot_bp,
  input  logic [1:0]       slot_adel_d,
  input  logic [1:0]       slot_ades_d,
  input  logic [1:0][31:0] slot_vaddr,
  input  logic [1:0]       slot_eret,
  input  logic [5:0]       ext_int,
  input  logic             status_ie,
  input  logic             status_exl,
  input  logic [7:0]       status_im,
  input  logic [1:0]       cause_ip_sw,
  input  logic             cause_ti,
  input  logic [31:0]      epc_in,
  output logic             exception_en,
  output logic [4:0]       exc_code,
  output logic [31:0]      exc_epc,
  output logic [31:0]      exc_badvaddr,
  output logic             exc_bd,
  output logic             eret_out,
  output logic [5:0]       ip_hw,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [4:0] EC_INT  = 5'd0;
  localparam logic [4:0] EC_ADEL = 5'd4;
  localparam logic [4:0] EC_ADES = 5'd5;
  localparam logic [4:0] EC_SYS  = 5'd8;
  localparam logic [4:0] EC_BP   = 5'd9;
  localparam logic [4:0] EC_RI   = 5'd10;
  localparam logic [4:0] EC_OV   = 5'd12;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    sync1;
  logic          int_req;

  logic [1:0]       hit;
  logic [1:0][4:0]  code;
  logic [1:0][31:0] badv;
  logic [1:0][31:0] epc_calc;

  logic        sel_exc, sel_eret;
  logic [4:0]  sel_code;
  logic [31:0] sel_epc, sel_bad;
  logic        sel_bd;

  logic        exc_en_d, eret_d, flush_d, rv_d, bd_d;
  logic [4:0]  code_d;
  logic [31:0] epc_d, bad_d, rpc_d;

  assign int_req = status_ie & ~status_exl &
                   (|(status_im & {ip_hw[5] | cause_ti, ip_hw[4:0], cause_ip_sw}));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      ip_hw <= '0;
    end else begin
      sync1 <= ext_int;
      ip_hw <= sync1;
    end
  end

  // Per-slot decode; an invalid slot never produces a hit.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hit[i]      = slot_valid[i] & (slot_adel_if[i] | slot_ri[i] | slot_ov[i] | slot_sys[i] |
                                     slot_bp[i] | slot_adel_d[i] | slot_ades_d[i]);
      code[i]     = EC_ADES;
      badv[i]     = '0;
      epc_calc[i] = slot_in_ds[i] ? slot_pc[i] - 32'd4 : slot_pc[i];
      if (slot_adel_if[i]) begin
        code[i] = EC_ADEL;
        badv[i] = slot_pc[i];
      end else if (slot_ri[i]) begin
        code[i] = EC_RI;
      end else if (slot_ov[i]) begin
        code[i] = EC_OV;
      end else if (slot_sys[i]) begin
        code[i] = EC_SYS;
      end else if (slot_bp[i]) begin
        code[i] = EC_BP;
      end else if (slot_adel_d[i]) begin
        code[i] = EC_ADEL;
        badv[i] = slot_vaddr[i];
      end else begin
        code[i] = EC_ADES;
        badv[i] = slot_vaddr[i];
      end
    end
  end

  // Global arbitration: interrupt on slot 0, then slot 0, then slot 1 unless slot 0 erets.
  always_comb begin
    sel_exc  = 1'b0;
    sel_eret = 1'b0;
    sel_code = '0;
    sel_epc  = '0;
    sel_bad  = '0;
    sel_bd   = 1'b0;
    if (int_req && slot_valid[0]) begin
      sel_exc  = 1'b1;
      sel_code = EC_INT;
      sel_epc  = epc_calc[0];
      sel_bd   = slot_in_ds[0];
    end else if (hit[0]) begin
      sel_exc  = 1'b1;
      sel_code = code[0];
      sel_epc  = epc_calc[0];
      sel_bad  = badv[0];
      sel_bd   = slot_in_ds[0];
    end else if (hit[1] && !(slot_valid[0] && slot_eret[0])) begin
      sel_exc  = 1'b1;
      sel_code = code[1];
      sel_epc  = epc_calc[1];
      sel_bad  = badv[1];
      sel_bd   = slot_in_ds[1];
    end else if (slot_valid[0] && slot_eret[0]) begin
      sel_eret = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    exc_en_d = 1'b0;
    eret_d   = 1'b0;
    rv_d     = 1'b0;
    flush_d  = 1'b0;
    code_d   = exc_code;
    epc_d    = exc_epc;
    bad_d    = exc_badvaddr;
    bd_d     = exc_bd;
    rpc_d    = redirect_pc;
    case (state_q)
      IDLE: begin
        if (sel_exc || sel_eret) begin
          flush_d = 1'b1;
          rv_d    = 1'b1;
          if (sel_exc) begin
            exc_en_d = 1'b1;
            rpc_d    = EXC_VECTOR;
            code_d   = sel_code;
            epc_d    = sel_epc;
            bad_d    = sel_bad;
            bd_d     = sel_bd;
          end else begin
            eret_d = 1'b1;
            rpc_d  = epc_in;
          end
          if (FLUSH_CYCLES > 1) begin
            state_d = HOLD;
            cnt_d   = CW'(FLUSH_CYCLES - 1);
          end
        end
      end
      HOLD: begin
        // The registered flush also covers the cycle after HOLD exits.
        flush_d = 1'b1;
        if (cnt_q == CW'(1)) state_d = IDLE;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      exception_en   <= 1'b0;
      eret_out       <= 1'b0;
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      exc_code       <= '0;
      exc_epc        <= '0;
      exc_badvaddr   <= '0;
      exc_bd         <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      exception_en   <= exc_en_d;
      eret_out       <= eret_d;
      redirect_valid <= rv_d;
      flush          <= flush_d;
      exc_code       <= code_d;
      exc_epc        <= epc_d;
      exc_badvaddr   <= bad_d;
      exc_bd         <= bd_d;
      redirect_pc    <= rpc_d;
    end
  end

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit: each step drives one cycle of inputs, queues the
// expected output bundle, and checks it one time unit after the following edge.
module tb_exception_unit;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       slot_valid, slot_in_ds, slot_adel_if, slot_ri, slot_ov, slot_sys, slot_bp;
  logic [1:0]       slot_adel_d, slot_ades_d, slot_eret;
  logic [1:0][31:0] slot_pc, slot_vaddr;
  logic [5:0]       ext_int;
  logic             status_ie, status_exl, cause_ti;
  logic [7:0]       status_im;
  logic [1:0]       cause_ip_sw;
  logic [31:0]      epc_in;
  logic             exception_en, exc_bd, eret_out, flush, redirect_valid;
  logic [4:0]       exc_code;
  logic [31:0]      exc_epc, exc_badvaddr, redirect_pc;
  logic [5:0]       ip_hw;

  exception_unit dut (
    .clk(clk), .reset(reset),
    .slot_valid(slot_valid), .slot_pc(slot_pc), .slot_in_ds(slot_in_ds),
    .slot_adel_if(slot_adel_if), .slot_ri(slot_ri), .slot_ov(slot_ov),
    .slot_sys(slot_sys), .slot_bp(slot_bp), .slot_adel_d(slot_adel_d),
    .slot_ades_d(slot_ades_d), .slot_vaddr(slot_vaddr), .slot_eret(slot_eret),
    .ext_int(ext_int), .status_ie(status_ie), .status_exl(status_exl),
    .status_im(status_im), .cause_ip_sw(cause_ip_sw), .cause_ti(cause_ti),
    .epc_in(epc_in), .exception_en(exception_en), .exc_code(exc_code),
    .exc_epc(exc_epc), .exc_badvaddr(exc_badvaddr), .exc_bd(exc_bd),
    .eret_out(eret_out), .ip_hw(ip_hw), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [111:0] exp_q[$];
  wire  [111:0] obs = {exception_en, exc_code, exc_epc, exc_badvaddr, exc_bd,
                       eret_out, flush, redirect_valid, redirect_pc, ip_hw};

  // Expected values of the held fields and synchroniser output.
  logic [4:0]  h_code = '0;
  logic [31:0] h_epc = '0, h_bad = '0, h_rpc = '0;
  logic        h_bd = 1'b0;
  logic [5:0]  h_ip = '0;

  function automatic logic [111:0] pk(input logic en, input logic eret, input logic fl,
                                      input logic rv);
    return {en, h_code, h_epc, h_bad, h_bd, eret, fl, rv, h_rpc, h_ip};
  endfunction

  task automatic check(input string tag, input logic [111:0] got, input logic [111:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [111:0] e);
    logic [111:0] x;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    check(tag, obs, x);
  endtask

  task automatic clear_slots();
    slot_valid = '0; slot_in_ds = '0; slot_adel_if = '0; slot_ri = '0; slot_ov = '0;
    slot_sys = '0; slot_bp = '0; slot_adel_d = '0; slot_ades_d = '0; slot_eret = '0;
    slot_pc = '0; slot_vaddr = '0;
  endtask

  task automatic exp_exc(input string tag, input logic [4:0] c, input logic [31:0] e,
                         input logic [31:0] b, input logic d);
    h_code = c; h_epc = e; h_bad = b; h_bd = d; h_rpc = VEC;
    cyc(tag, pk(1'b1, 1'b0, 1'b1, 1'b1));
  endtask

  task automatic exp_quiet(input string tag, input logic fl);
    cyc(tag, pk(1'b0, 1'b0, fl, 1'b0));
  endtask

  task automatic drain(input string tag);
    clear_slots();
    exp_quiet({tag, "_fl2"}, 1'b1);
    exp_quiet({tag, "_fl3"}, 1'b1);
    exp_quiet({tag, "_fl_end"}, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_slots();
    ext_int = '0; status_ie = 1'b0; status_exl = 1'b0; status_im = '0;
    cause_ip_sw = '0; cause_ti = 1'b0; epc_in = '0;
    #1 reset = 1'b1;
    #1 check("reset_state", obs, '0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Overflow in slot 0, flush for three cycles.
    slot_valid = 2'b01; slot_pc[0] = 32'h8000_1000; slot_ov[0] = 1'b1;
    exp_exc("ov_slot0", 5'd12, 32'h8000_1000, 32'h0, 1'b0);
    drain("ov");

    // Delay-slot store error in slot 0 beats slot 1 syscall.
    slot_valid = 2'b11; slot_in_ds[0] = 1'b1; slot_pc[0] = 32'h8000_2004;
    slot_ades_d[0] = 1'b1; slot_vaddr[0] = 32'h0000_0003;
    slot_sys[1] = 1'b1; slot_pc[1] = 32'h8000_2008;
    exp_exc("ades_ds", 5'd5, 32'h8000_2000, 32'h0000_0003, 1'b1);
    drain("ades");

    // Slot 1 break taken when slot 0 is clean.
    slot_valid = 2'b11; slot_pc[0] = 32'h8000_5004; slot_bp[1] = 1'b1; slot_pc[1] = 32'h8000_5008;
    exp_exc("bp_slot1", 5'd9, 32'h8000_5008, 32'h0, 1'b0);
    drain("bp");

    // Fetch error outranks ri; delay slot at pc 0 wraps EPC.
    slot_valid = 2'b01; slot_in_ds[0] = 1'b1; slot_pc[0] = 32'h0;
    slot_adel_if[0] = 1'b1; slot_ri[0] = 1'b1;
    exp_exc("adel_if_wrap", 5'd4, 32'hFFFF_FFFC, 32'h0, 1'b1);
    drain("adel_if");

    // Invalid slot 1 with an exception is ignored.
    slot_valid = 2'b00; slot_ov[1] = 1'b1; slot_pc[1] = 32'h8000_6000;
    exp_quiet("invalid_slot1", 1'b0);
    clear_slots();

    // Hardware interrupt through the synchroniser.
    status_ie = 1'b1; status_im = 8'h04; ext_int = 6'h01;
    exp_quiet("sync_stage1", 1'b0);
    h_ip = 6'h01;
    exp_quiet("sync_stage2", 1'b0);
    exp_quiet("int_pending_no_slot", 1'b0);
    slot_valid = 2'b01; slot_pc[0] = 32'h8000_3000;
    exp_exc("int_taken", 5'd0, 32'h8000_3000, 32'h0, 1'b0);
    drain("int");
    status_exl = 1'b1; slot_valid = 2'b01; slot_pc[0] = 32'h8000_3000;
    exp_quiet("int_masked_exl", 1'b0);
    clear_slots();
    status_ie = 1'b0; status_exl = 1'b0; ext_int = '0;
    exp_quiet("sync_fall1", 1'b0);
    h_ip = '0;
    exp_quiet("sync_fall2", 1'b0);

    // eret in slot 0, then slot-1-only eret.
    slot_valid = 2'b11; slot_eret[0] = 1'b1; slot_pc[0] = 32'h8000_4100; epc_in = 32'h8000_4000;
    slot_ri[1] = 1'b1;
    h_rpc = 32'h8000_4000;
    cyc("eret_slot0", pk(1'b0, 1'b1, 1'b1, 1'b1));
    drain("eret");
    slot_valid = 2'b10; slot_eret[1] = 1'b1;
    exp_quiet("eret_slot1_ignored", 1'b0);
    clear_slots();

    // New ri during HOLD is ignored; taken on the fourth cycle.
    slot_valid = 2'b01; slot_pc[0] = 32'h8000_7000; slot_ri[0] = 1'b1;
    exp_exc("ri_first", 5'd10, 32'h8000_7000, 32'h0, 1'b0);
    slot_pc[0] = 32'h8000_7100;
    exp_quiet("ri_hold1", 1'b1);
    exp_quiet("ri_hold2", 1'b1);
    exp_exc("ri_after_hold", 5'd10, 32'h8000_7100, 32'h0, 1'b0);
    drain("ri");

    // Reset in the middle of HOLD.
    slot_valid = 2'b01; slot_pc[0] = 32'h8000_8000; slot_ov[0] = 1'b1;
    exp_exc("ov_before_reset", 5'd12, 32'h8000_8000, 32'h0, 1'b0);
    clear_slots();
    #2 reset = 1'b1;
    h_code = '0; h_epc = '0; h_bad = '0; h_bd = 1'b0; h_rpc = '0; h_ip = '0;
    #1 check("reset_mid_hold", obs, '0);
    #1 reset = 1'b0;
    exp_quiet("after_reset_idle", 1'b0);
    slot_valid = 2'b01; slot_pc[0] = 32'h8000_9000; slot_sys[0] = 1'b1;
    exp_exc("sys_after_reset", 5'd8, 32'h8000_9000, 32'h0, 1'b0);
    drain("sys");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
